// File: rtl/sw_seq_loader.sv
// sw_seq_loader: buffers a host query and database sequence of 2-bit symbols,
// streams them to a Smith-Waterman core, issues a start command and captures
// the core's best score.
// Optional feature: define SW_LOADER_PERF_EN to count compute cycles between
// the start command and the result capture (cycle_count); otherwise it is 0.
module sw_seq_loader #(
  parameter int unsigned MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_base,
  input  logic        in_last,
  output logic [1:0]  Read_en,
  output logic [1:0]  data_readin,
  input  logic        sw_valid,
  input  logic [15:0] max_result,
  output logic [15:0] result,
  output logic        done,
  output logic        err,
  output logic [31:0] cycle_count
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] FULL  = CW'(MAX_LEN);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [AW-1:0] ADDR0 = '0;

  localparam logic [1:0] RE_IDLE  = 2'b00;
  localparam logic [1:0] RE_QRY   = 2'b01;
  localparam logic [1:0] RE_DB    = 2'b10;
  localparam logic [1:0] RE_START = 2'b11;

  typedef enum logic [2:0] {
    LOAD_Q,
    LOAD_D,
    STREAM_Q,
    STREAM_D,
    START,
    WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] qcnt;
  logic [CW-1:0] dcnt;
  logic [CW-1:0] idx;
  logic [1:0]    qbuf [MAX_LEN];
  logic [1:0]    dbuf [MAX_LEN];

  logic accept;
  logic q_full;
  logic d_full;
  logic q_more;
  logic d_more;

  assign accept = in_valid && in_ready;
  assign q_full = (qcnt == FULL);
  assign d_full = (dcnt == FULL);
  assign q_more = (idx < qcnt);
  assign d_more = (idx < dcnt);

  // Symbol storage; beats arriving at a full buffer are dropped.
  always_ff @(posedge clk) begin
    if (accept && (state == LOAD_Q) && !q_full) qbuf[AW'(qcnt)] <= in_base;
    if (accept && (state == LOAD_D) && !d_full) dbuf[AW'(dcnt)] <= in_base;
  end

  // Control FSM with registered handshake and core command outputs.
  // Both counts are at least 1 when streaming starts: the in_last beat is
  // either stored or dropped because the buffer is already full.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD_Q;
      qcnt        <= '0;
      dcnt        <= '0;
      idx         <= '0;
      in_ready    <= 1'b0;
      Read_en     <= RE_IDLE;
      data_readin <= 2'b00;
      result      <= 16'd0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done        <= 1'b0;
      in_ready    <= 1'b0;
      Read_en     <= RE_IDLE;
      data_readin <= 2'b00;
      case (state)
        LOAD_Q: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (q_full) err <= 1'b1;
            else        qcnt <= qcnt + ONE;
            if (in_last) state <= LOAD_D;
          end
        end
        LOAD_D: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (d_full) err <= 1'b1;
            else        dcnt <= dcnt + ONE;
            if (in_last) begin
              state       <= STREAM_Q;
              in_ready    <= 1'b0;
              Read_en     <= RE_QRY;
              data_readin <= qbuf[ADDR0];
              idx         <= ONE;
            end
          end
        end
        STREAM_Q: begin
          if (q_more) begin
            Read_en     <= RE_QRY;
            data_readin <= qbuf[AW'(idx)];
            idx         <= idx + ONE;
          end else begin
            state       <= STREAM_D;
            Read_en     <= RE_DB;
            data_readin <= dbuf[ADDR0];
            idx         <= ONE;
          end
        end
        STREAM_D: begin
          if (d_more) begin
            Read_en     <= RE_DB;
            data_readin <= dbuf[AW'(idx)];
            idx         <= idx + ONE;
          end else begin
            state   <= START;
            Read_en <= RE_START;
            idx     <= '0;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (sw_valid) begin
            result   <= max_result;
            done     <= 1'b1;
            qcnt     <= '0;
            dcnt     <= '0;
            in_ready <= 1'b1;
            state    <= LOAD_Q;
          end
        end
        default: begin
          state <= LOAD_Q;
        end
      endcase
    end
  end

`ifdef SW_LOADER_PERF_EN
  logic start_entry;
  assign start_entry = (state == STREAM_D) && !d_more;

  // Compute-cycle counter: cleared entering START, counts WAIT cycles.
  always_ff @(posedge clk) begin
    if (rst)                 cycle_count <= 32'd0;
    else if (start_entry)    cycle_count <= 32'd0;
    else if (state == WAIT)  cycle_count <= cycle_count + 32'd1;
  end
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_sw_seq_loader.sv
// Scoreboard bench for sw_seq_loader (MAX_LEN=4): stimulus pushes expected
// command beats and captured scores; a negedge monitor pops and compares.
module tb_sw_seq_loader;

`ifdef SW_LOADER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_base;
  logic        in_last;
  logic [1:0]  Read_en;
  logic [1:0]  data_readin;
  logic        sw_valid;
  logic [15:0] max_result;
  logic [15:0] result;
  logic        done;
  logic        err;
  logic [31:0] cycle_count;

  typedef struct {
    logic [1:0] re;
    logic [1:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] res_q[$];
  int checks   = 0;
  int failures = 0;

  sw_seq_loader #(.MAX_LEN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_base     (in_base),
    .in_last     (in_last),
    .Read_en     (Read_en),
    .data_readin (data_readin),
    .sw_valid    (sw_valid),
    .max_result  (max_result),
    .result      (result),
    .done        (done),
    .err         (err),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic [1:0] re, input logic [1:0] d);
    exp_t e;
    e.re = re;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  // Presents one beat; called at a negedge, returns at the negedge after acceptance.
  task automatic send(input logic [1:0] b, input logic l);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_base  = b;
    in_last  = l;
    @(negedge clk);
  endtask

  task automatic wait_start();
    int t = 0;
    while (Read_en != 2'b11 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("start_seen", 32'(Read_en), 32'd3);
  endtask

  // Called in the START cycle; sw_valid is sampled k cycles later.
  task automatic capture(input int k, input logic [15:0] val);
    repeat (k) @(negedge clk);
    in_valid   = 1'b0;
    in_last    = 1'b0;
    sw_valid   = 1'b1;
    max_result = val;
    res_q.push_back(val);
    @(negedge clk);
    sw_valid   = 1'b0;
    max_result = 16'hFFFF;
    chk("cap_done",     32'(done),     32'd1);
    chk("cap_ready",    32'(in_ready), 32'd1);
    chk("cap_read_en",  32'(Read_en),  32'd0);
    chk("cap_cycles",   cycle_count,   PERF ? 32'(k) : 32'd0);
    @(negedge clk);
    chk("done_pulse",   32'(done),     32'd0);
    chk("result_hold",  32'(result),   32'(val));
    chk("cycles_hold",  cycle_count,   PERF ? 32'(k) : 32'd0);
  endtask

  // Monitor: compares every command beat and every captured score.
  always @(negedge clk) begin
    if (Read_en != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", 32'(Read_en), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cmd_read_en", 32'(Read_en), 32'(e.re));
        if (e.re != 2'b11) chk("cmd_data", 32'(data_readin), 32'(e.d));
      end
    end
    if (done) begin
      if (res_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [15:0] r;
        r = res_q.pop_front();
        chk("result", 32'(result), 32'(r));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_base    = 2'b00;
    in_last    = 1'b0;
    sw_valid   = 1'b0;
    max_result = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready",   32'(in_ready),    32'd0);
    chk("rst_read_en", 32'(Read_en),     32'd0);
    chk("rst_data",    32'(data_readin), 32'd0);
    chk("rst_result",  32'(result),      32'd0);
    chk("rst_done",    32'(done),        32'd0);
    chk("rst_err",     32'(err),         32'd0);
    chk("rst_cycles",  cycle_count,      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Query ACGT fills the buffer exactly, database GGA; in_valid held through streaming.
    push_cmd(2'b01, 2'd0); push_cmd(2'b01, 2'd1); push_cmd(2'b01, 2'd2); push_cmd(2'b01, 2'd3);
    push_cmd(2'b10, 2'd2); push_cmd(2'b10, 2'd2); push_cmd(2'b10, 2'd0); push_cmd(2'b11, 2'd0);
    send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b1);
    send(2'd2, 1'b0); send(2'd2, 1'b0); send(2'd0, 1'b1);
    in_valid = 1'b1;
    in_base  = 2'd3;
    in_last  = 1'b0;
    wait_start();
    chk("stream_ready_low", 32'(in_ready), 32'd0);
    capture(10, 16'd7);
    chk("full_no_err", 32'(err), 32'd0);

    // sw_valid outside WAIT is ignored.
    sw_valid   = 1'b1;
    max_result = 16'd99;
    @(negedge clk);
    sw_valid = 1'b0;
    @(negedge clk);
    chk("ignore_sw_done",   32'(done),   32'd0);
    chk("ignore_sw_result", 32'(result), 32'd7);

    // Overflow: six query symbols C G T A C G, only the first four kept.
    push_cmd(2'b01, 2'd1); push_cmd(2'b01, 2'd2); push_cmd(2'b01, 2'd3); push_cmd(2'b01, 2'd0);
    push_cmd(2'b10, 2'd3); push_cmd(2'b11, 2'd0);
    send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0);
    chk("no_err_yet", 32'(err), 32'd0);
    send(2'd1, 1'b0);
    chk("err_set", 32'(err), 32'd1);
    send(2'd2, 1'b1);
    send(2'd3, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_start();
    capture(3, 16'hBEEF);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset in the middle of the database stream.
    push_cmd(2'b01, 2'd0); push_cmd(2'b10, 2'd1);
    send(2'd0, 1'b1);
    send(2'd1, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    begin
      int t = 0;
      while (Read_en != 2'b10 && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_read_en", 32'(Read_en),  32'd0);
    chk("midrst_result",  32'(result),   32'd0);
    chk("midrst_err",     32'(err),      32'd0);
    chk("midrst_ready",   32'(in_ready), 32'd0);
    chk("midrst_cycles",  cycle_count,   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", 32'(in_ready), 32'd1);

    // Short sequence after reset confirms counts were cleared.
    push_cmd(2'b01, 2'd3); push_cmd(2'b01, 2'd3); push_cmd(2'b10, 2'd1); push_cmd(2'b11, 2'd0);
    send(2'd3, 1'b0); send(2'd3, 1'b1);
    send(2'd1, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_start();
    capture(2, 16'd300);

    repeat (5) @(negedge clk);
    chk("cmd_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("res_queue_empty", 32'(res_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_seq_loader.md
SW_SEQ_LOADER -- requirements
Module: sw_seq_loader

Interface
REQ-001 Parameter MAX_LEN, default 64, gives the capacity in 2-bit symbols of each of the query buffer and the database buffer.
REQ-002 clk  input  1  single clock; every register updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  host symbol beat valid.
REQ-005 in_ready  output  1  loader accepts a beat this cycle.
REQ-006 in_base  input  2  nucleotide code (A=00, C=01, G=10, T=11).
REQ-007 in_last  input  1  marks the final symbol of the current sequence.
REQ-008 Read_en  output  2  command to the SW core (00 idle, 01 query symbol, 10 database symbol, 11 start).
REQ-009 data_readin  output  2  symbol sent to the SW core alongside Read_en.
REQ-010 sw_valid  input  1  SW core result valid.
REQ-011 max_result  input  16  SW core best score.
REQ-012 result  output  16  captured score.
REQ-013 done  output  1  one-cycle pulse when result updates.
REQ-014 err  output  1  sticky overflow flag.
REQ-015 cycle_count  output  32  compute-cycle count (see Configuration).

Function
REQ-016 The FSM states shall be LOAD_Q, LOAD_D, STREAM_Q, STREAM_D, START and WAIT.
REQ-017 A beat shall be accepted in any cycle where in_valid and in_ready are both high.
REQ-018 in_ready shall be high only in LOAD_Q and LOAD_D.
REQ-019 In LOAD_Q, each accepted beat shall be written to qbuf[qcnt] and qcnt shall increment; an accepted beat with in_last shall move the FSM to LOAD_D.
REQ-020 In LOAD_D, each accepted beat shall be written to dbuf[dcnt] and dcnt shall increment; an accepted beat with in_last shall move the FSM to STREAM_Q.
REQ-021 On a full buffer (count == MAX_LEN), an accepted beat shall be dropped, the count shall hold, and err shall be set; in_last on that dropped beat shall still advance the FSM.
REQ-022 Counter width shall be clog2(MAX_LEN+1) bits; the read index shall never wrap past the stored count.
REQ-023 In STREAM_Q, the block shall drive Read_en=01 with data_readin=qbuf[i] for i = 0..qcnt-1, one symbol per cycle, with no gaps.
REQ-024 STREAM_D shall then drive Read_en=10 with dbuf[j] for j = 0..dcnt-1 in the same way.
REQ-025 START shall drive Read_en=11 for exactly one cycle, followed by WAIT.
REQ-026 Read_en and data_readin shall be registered outputs; the first Read_en=01 shall appear on the cycle after the final LOAD_D beat is accepted.
REQ-027 Outside STREAM_Q, STREAM_D and START, Read_en shall be 00 and data_readin shall be 00.
REQ-028 In WAIT, sw_valid=1 shall capture max_result into result, pulse done for one cycle, clear qcnt and dcnt, and move the FSM to LOAD_Q.
REQ-029 sw_valid shall be ignored in every state other than WAIT.
REQ-030 result shall hold its value until the next capture.
REQ-031 err shall stay set until rst.

Reset
REQ-032 When rst is high at a rising edge, the FSM shall return to LOAD_Q from any state, including mid-stream or WAIT.
REQ-033 Reset values: qcnt=0, dcnt=0, Read_en=00, data_readin=00, result=0, done=0, err=0, cycle_count=0, in_ready=0 during the rst cycle.
REQ-034 Buffer contents need not be reset.
REQ-035 in_ready shall go high on the first cycle after rst deasserts.

Configuration
REQ-036 With SW_LOADER_PERF_EN defined, cycle_count shall clear on entry to START, increment every cycle in WAIT, and hold after capture until the next START.
REQ-037 Without SW_LOADER_PERF_EN, cycle_count shall be constant 0 and no counter logic shall be synthesized.

Verification
REQ-038 Load query ACGT (in_last on T), then database GGA (in_last on A) -> Read_en/data_readin sequence 01/00, 01/01, 01/10, 01/11, 10/10, 10/10, 10/00, 11/xx, then 00.
REQ-039 In WAIT, apply max_result=16'd7 with sw_valid=1 for one cycle -> result=7, done high for exactly one cycle, in_ready high on the next cycle.
REQ-040 MAX_LEN=4; send 6 query symbols with in_last on the 6th -> qcnt=4, err=1, streaming emits only the first 4 query symbols.
REQ-041 Hold in_valid high continuously through streaming -> no beats accepted and no buffer change until LOAD_Q.
REQ-042 Assert rst during STREAM_D -> next cycle Read_en=00, FSM in LOAD_Q, result=0, err=0.
REQ-043 With SW_LOADER_PERF_EN defined, sw_valid arrives 10 cycles after the START cycle -> cycle_count=10; without the macro, cycle_count=0.
